// File: rtl/disp_pkg.sv
// Shared mode encodings, Bayer threshold lookup and width-conversion helpers
// for the display colour adapter.
package disp_pkg;

  localparam logic [1:0] MODE_CONV  = 2'd0;
  localparam logic [1:0] MODE_DITH  = 2'd1;
  localparam logic [1:0] MODE_GREY  = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  // Number of MSB-first copies needed to fill the output width.
  function automatic int rep_count(input int bpc_in, input int bpc_out);
    return (bpc_out + bpc_in - 1) / bpc_in;
  endfunction

  // Bits dropped on reduction; zero when expanding.
  function automatic int red_shift(input int bpc_in, input int bpc_out);
    if (bpc_in > bpc_out) begin
      return bpc_in - bpc_out;
    end else begin
      return 0;
    end
  endfunction

  // 2x2 Bayer [[0,2],[3,1]] indexed [y][x].
  function automatic logic [1:0] bayer2(input logic x0, input logic y0);
    return {x0 ^ y0, y0};
  endfunction

  // Recursive Bayer: 4x4 entry = 4*M2(low bits) + M2(high bits).
  function automatic logic [3:0] bayer(input logic [1:0] x, input logic [1:0] y, input int dw);
    logic [3:0] t;
    if (dw >= 2) begin
      t = {bayer2(x[0], y[0]), bayer2(x[1], y[1])};
    end else begin
      t = {2'b00, bayer2(x[0], y[0])};
    end
    return t;
  endfunction

endpackage

// File: rtl/disp_colr_width.sv
// One colour channel: bit-replicate expansion or truncate/dither reduction
// with saturation, blank forcing, and the stage-2 output register.
module colr_width
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BPC_IN-1:0]  c_i,
  input  logic [BPC_IN-1:0]  thr_i,
  input  logic               dith_i,
  input  logic               blank_i,
  output logic [BPC_OUT-1:0] c_o
);

  logic [BPC_OUT-1:0] conv_s;
  logic [BPC_OUT-1:0] c_d;
  logic [BPC_OUT-1:0] c_q;

  generate
    if (BPC_OUT >= BPC_IN) begin : g_expand
      localparam int REP = rep_count(BPC_IN, BPC_OUT);
      logic [REP*BPC_IN-1:0] rep_s;
      logic                  unused_dith_s;

      assign rep_s         = {REP{c_i}};
      assign conv_s        = BPC_OUT'(rep_s >> (REP * BPC_IN - BPC_OUT));
      assign unused_dith_s = ^{thr_i, dith_i};
    end else begin : g_reduce
      localparam int D = red_shift(BPC_IN, BPC_OUT);
      logic [BPC_IN:0]   sum_s;
      logic [BPC_IN-1:0] sat_s;

      // The extra carry bit catches overflow so bright pixels clamp instead of wrapping.
      always_comb begin
        sum_s = {1'b0, c_i} + {1'b0, thr_i};
        if (dith_i && sum_s[BPC_IN]) begin
          sat_s = {BPC_IN{1'b1}};
        end else if (dith_i) begin
          sat_s = sum_s[BPC_IN-1:0];
        end else begin
          sat_s = c_i;
        end
      end

      assign conv_s = BPC_OUT'(sat_s >> D);
    end
  endgenerate

  always_comb begin
    if (blank_i) begin
      c_d = {BPC_OUT{1'b0}};
    end else begin
      c_d = conv_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q <= {BPC_OUT{1'b0}};
    end else begin
      c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/disp_colr_adapt.sv
// Display colour adapter: frame-latched mode, stage-1 greyscale/threshold
// capture, and three per-channel converters forming stage 2.
module disp_colr_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8,
  parameter int CORDW    = 16,
  parameter int DITHER_W = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [1:0]              mode_req,
  input  logic signed [CORDW-1:0] in_x,
  input  logic signed [CORDW-1:0] in_y,
  input  logic                    in_de,
  input  logic                    in_frame,
  input  logic [BPC_IN-1:0]       in_r,
  input  logic [BPC_IN-1:0]       in_g,
  input  logic [BPC_IN-1:0]       in_b,
  output logic signed [CORDW-1:0] out_x,
  output logic signed [CORDW-1:0] out_y,
  output logic                    out_de,
  output logic                    out_frame,
  output logic [BPC_OUT-1:0]      out_r,
  output logic [BPC_OUT-1:0]      out_g,
  output logic [BPC_OUT-1:0]      out_b,
  output logic [1:0]              mode_cur
);

  localparam int RED_D = red_shift(BPC_IN, BPC_OUT);
  localparam int GW    = BPC_IN + 3;

  logic [1:0]              mode_eff_s;
  logic [1:0]              mode_cur_d, mode_cur_q;
  logic [GW-1:0]           gr_s, gg_s, gb_s;
  logic [BPC_IN-1:0]       grey_s;
  logic [31:0]             t_wide_s;
  logic [BPC_IN-1:0]       thr_d;
  logic [BPC_IN-1:0]       r_d, g_d, b_d;

  logic signed [CORDW-1:0] s1_x_q, s1_y_q, s2_x_q, s2_y_q;
  logic                    s1_de_q, s1_frame_q, s2_de_q, s2_frame_q;
  logic [1:0]              s1_mode_q;
  logic [BPC_IN-1:0]       s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
  logic                    dith_s, blank_s;

  // The frame-start pixel already uses the requested mode; the register follows a cycle later.
  always_comb begin
    if (in_frame) begin
      mode_eff_s = mode_req;
    end else begin
      mode_eff_s = mode_cur_q;
    end
    mode_cur_d = mode_eff_s;
  end

  always_comb begin
    gr_s     = {3'b000, in_r};
    gg_s     = {3'b000, in_g};
    gb_s     = {3'b000, in_b};
    grey_s   = BPC_IN'(((gr_s << 3'd1) + (gg_s << 3'd2) + gg_s + gb_s) >> 3'd3);
    t_wide_s = {28'd0, bayer(in_x[1:0], in_y[1:0], DITHER_W)};
    thr_d    = BPC_IN'((t_wide_s << RED_D) >> (2 * DITHER_W));
    if (mode_eff_s == MODE_GREY) begin
      r_d = grey_s;
      g_d = grey_s;
      b_d = grey_s;
    end else begin
      r_d = in_r;
      g_d = in_g;
      b_d = in_b;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      mode_cur_q <= 2'd0;
      s1_x_q     <= {CORDW{1'b0}};
      s1_y_q     <= {CORDW{1'b0}};
      s1_de_q    <= 1'b0;
      s1_frame_q <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_r_q     <= {BPC_IN{1'b0}};
      s1_g_q     <= {BPC_IN{1'b0}};
      s1_b_q     <= {BPC_IN{1'b0}};
      s1_thr_q   <= {BPC_IN{1'b0}};
    end else begin
      mode_cur_q <= mode_cur_d;
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_de_q    <= in_de;
      s1_frame_q <= in_frame;
      s1_mode_q  <= mode_eff_s;
      s1_r_q     <= r_d;
      s1_g_q     <= g_d;
      s1_b_q     <= b_d;
      s1_thr_q   <= thr_d;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      s2_x_q     <= {CORDW{1'b0}};
      s2_y_q     <= {CORDW{1'b0}};
      s2_de_q    <= 1'b0;
      s2_frame_q <= 1'b0;
    end else begin
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_de_q    <= s1_de_q;
      s2_frame_q <= s1_frame_q;
    end
  end

  always_comb begin
    dith_s  = (s1_mode_q == MODE_DITH);
    blank_s = (s1_mode_q == MODE_BLANK) || !s1_de_q;
  end

  colr_width #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_r (
    .clk_i(clk_pix), .rst_i(rst_pix), .c_i(s1_r_q), .thr_i(s1_thr_q),
    .dith_i(dith_s), .blank_i(blank_s), .c_o(out_r)
  );

  colr_width #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_g (
    .clk_i(clk_pix), .rst_i(rst_pix), .c_i(s1_g_q), .thr_i(s1_thr_q),
    .dith_i(dith_s), .blank_i(blank_s), .c_o(out_g)
  );

  colr_width #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_b (
    .clk_i(clk_pix), .rst_i(rst_pix), .c_i(s1_b_q), .thr_i(s1_thr_q),
    .dith_i(dith_s), .blank_i(blank_s), .c_o(out_b)
  );

  assign out_x     = s2_x_q;
  assign out_y     = s2_y_q;
  assign out_de    = s2_de_q;
  assign out_frame = s2_frame_q;
  assign mode_cur  = mode_cur_q;

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Scoreboard bench: a 5->8 expanding instance and an 8->5 dithering instance,
// expected pixels queued at issue and checked by per-instance monitors.
module tb_disp_colr_adapt;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  always #5 clk_pix = ~clk_pix;

  // Expanding instance (5 -> 8)
  logic [1:0]  e_mode = 2'd0;
  logic [15:0] e_x = 16'd0, e_y = 16'd0;
  logic        e_de = 1'b0, e_fr = 1'b0;
  logic [4:0]  e_r = 5'd0, e_g = 5'd0, e_b = 5'd0;
  logic [15:0] e_ox, e_oy;
  logic        e_ode, e_ofr;
  logic [7:0]  e_or, e_og, e_ob;
  logic [1:0]  e_mcur;

  // Reducing instance (8 -> 5)
  logic [1:0]  r_mode = 2'd0;
  logic [15:0] r_x = 16'd0, r_y = 16'd0;
  logic        r_de = 1'b0, r_fr = 1'b0;
  logic [7:0]  r_r = 8'd0, r_g = 8'd0, r_b = 8'd0;
  logic [15:0] r_ox, r_oy;
  logic        r_ode, r_ofr;
  logic [4:0]  r_or, r_og, r_ob;
  logic [1:0]  r_mcur;

  disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CORDW(16), .DITHER_W(1)) u_exp (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(e_mode), .in_x(e_x), .in_y(e_y),
    .in_de(e_de), .in_frame(e_fr), .in_r(e_r), .in_g(e_g), .in_b(e_b),
    .out_x(e_ox), .out_y(e_oy), .out_de(e_ode), .out_frame(e_ofr),
    .out_r(e_or), .out_g(e_og), .out_b(e_ob), .mode_cur(e_mcur)
  );

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16), .DITHER_W(1)) u_red (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(r_mode), .in_x(r_x), .in_y(r_y),
    .in_de(r_de), .in_frame(r_fr), .in_r(r_r), .in_g(r_g), .in_b(r_b),
    .out_x(r_ox), .out_y(r_oy), .out_de(r_ode), .out_frame(r_ofr),
    .out_r(r_or), .out_g(r_og), .out_b(r_ob), .mode_cur(r_mcur)
  );

  typedef struct {
    int          due;
    logic [15:0] x, y;
    logic        de, fr;
    logic [7:0]  r, g, b;
  } exp_t;

  exp_t qe[$];
  exp_t qr[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_pix) begin : mon_e
    exp_t e;
    if (qe.size() > 0 && qe[0].due <= cyc) begin
      e = qe.pop_front();
      if (e.due != cyc) begin
        chk("e_missed", 32'(cyc), 32'(e.due));
      end else begin
        chk("e_x",  {16'd0, e_ox}, {16'd0, e.x});
        chk("e_y",  {16'd0, e_oy}, {16'd0, e.y});
        chk("e_de", {31'd0, e_ode}, {31'd0, e.de});
        chk("e_fr", {31'd0, e_ofr}, {31'd0, e.fr});
        chk("e_r",  {24'd0, e_or}, {24'd0, e.r});
        chk("e_g",  {24'd0, e_og}, {24'd0, e.g});
        chk("e_b",  {24'd0, e_ob}, {24'd0, e.b});
      end
    end
  end

  always @(negedge clk_pix) begin : mon_r
    exp_t e;
    if (qr.size() > 0 && qr[0].due <= cyc) begin
      e = qr.pop_front();
      if (e.due != cyc) begin
        chk("r_missed", 32'(cyc), 32'(e.due));
      end else begin
        chk("r_x",  {16'd0, r_ox}, {16'd0, e.x});
        chk("r_y",  {16'd0, r_oy}, {16'd0, e.y});
        chk("r_de", {31'd0, r_ode}, {31'd0, e.de});
        chk("r_fr", {31'd0, r_ofr}, {31'd0, e.fr});
        chk("r_r",  {27'd0, r_or}, {24'd0, e.r});
        chk("r_g",  {27'd0, r_og}, {24'd0, e.g});
        chk("r_b",  {27'd0, r_ob}, {24'd0, e.b});
      end
    end
  end

  task automatic step_e(input logic [1:0] m, input logic fr, input logic de, input int x, input int y,
                        input logic [4:0] r, input logic [4:0] g, input logic [4:0] b,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    exp_t e;
    @(posedge clk_pix); #1;
    e_mode = m; e_fr = fr; e_de = de; e_x = 16'(x); e_y = 16'(y);
    e_r = r; e_g = g; e_b = b;
    e.due = cyc + 2; e.x = 16'(x); e.y = 16'(y); e.de = de; e.fr = fr;
    e.r = er; e.g = eg; e.b = eb;
    qe.push_back(e);
  endtask

  task automatic step_r(input logic [1:0] m, input logic fr, input logic de, input int x, input int y,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    exp_t e;
    @(posedge clk_pix); #1;
    r_mode = m; r_fr = fr; r_de = de; r_x = 16'(x); r_y = 16'(y);
    r_r = r; r_g = g; r_b = b;
    e.due = cyc + 2; e.x = 16'(x); e.y = 16'(y); e.de = de; e.fr = fr;
    e.r = er; e.g = eg; e.b = eb;
    qr.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk_pix);
    @(negedge clk_pix);
    chk("rst_e_r",    {24'd0, e_or}, 32'd0);
    chk("rst_e_x",    {16'd0, e_ox}, 32'd0);
    chk("rst_e_de",   {31'd0, e_ode}, 32'd0);
    chk("rst_e_mcur", {30'd0, e_mcur}, 32'd0);
    chk("rst_r_g",    {27'd0, r_og}, 32'd0);
    chk("rst_r_mcur", {30'd0, r_mcur}, 32'd0);
    rst_pix = 1'b0;

    // Expansion, mode 0; the frame pixel switches from the reset mode
    step_e(2'd0, 1'b1, 1'b1,  0,  0, 5'h1F, 5'h10, 5'h00, 8'hFF, 8'h84, 8'h00);
    step_e(2'd0, 1'b0, 1'b1,  1,  0, 5'h10, 5'h00, 5'h1F, 8'h84, 8'h00, 8'hFF);
    step_e(2'd0, 1'b0, 1'b1, -3, -7, 5'h00, 5'h1F, 5'h10, 8'h00, 8'hFF, 8'h84);
    // Greyscale latched at frame start
    step_e(2'd2, 1'b1, 1'b1,  5,  3, 5'd31, 5'd0,  5'd0,  8'h39, 8'h39, 8'h39);
    step_e(2'd2, 1'b0, 1'b1,  6,  3, 5'd0,  5'd31, 5'd0,  8'h9C, 8'h9C, 8'h9C);
    step_e(2'd2, 1'b0, 1'b1,  7,  3, 5'd31, 5'd31, 5'd31, 8'hFF, 8'hFF, 8'hFF);
    chk("mcur_grey", {30'd0, e_mcur}, 32'd2);
    // Blank requested mid-frame is ignored
    step_e(2'd3, 1'b0, 1'b1,  8,  3, 5'd31, 5'd0,  5'd0,  8'h39, 8'h39, 8'h39);
    chk("mcur_mid1", {30'd0, e_mcur}, 32'd2);
    step_e(2'd3, 1'b0, 1'b1,  9,  3, 5'd0,  5'd31, 5'd0,  8'h9C, 8'h9C, 8'h9C);
    chk("mcur_mid2", {30'd0, e_mcur}, 32'd2);
    // Blank takes effect on the next frame pixel; mode_cur follows a cycle later
    step_e(2'd3, 1'b1, 1'b1,  0,  0, 5'h1F, 5'h1F, 5'h1F, 8'h00, 8'h00, 8'h00);
    chk("mcur_pre", {30'd0, e_mcur}, 32'd2);
    step_e(2'd0, 1'b0, 1'b1,  1,  0, 5'h1F, 5'h1F, 5'h1F, 8'h00, 8'h00, 8'h00);
    chk("mcur_blank", {30'd0, e_mcur}, 32'd3);
    // Back to convert, then de=0 blanking
    step_e(2'd0, 1'b1, 1'b1,  0,  0, 5'h1F, 5'h00, 5'h00, 8'hFF, 8'h00, 8'h00);
    step_e(2'd0, 1'b0, 1'b0,  1,  0, 5'h1F, 5'h1F, 5'h1F, 8'h00, 8'h00, 8'h00);
    step_e(2'd0, 1'b0, 1'b1,  2,  0, 5'h1F, 5'h00, 5'h10, 8'hFF, 8'h00, 8'h84);

    // Reduction with 2x2 dither: r=0x0B, g=0xFF saturates, b=0x1A
    step_r(2'd1, 1'b1, 1'b1,  0,  0, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd1, 1'b0, 1'b1,  1,  0, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd1, 1'b0, 1'b1,  0,  1, 8'h0B, 8'hFF, 8'h1A, 8'h02, 8'h1F, 8'h04);
    step_r(2'd1, 1'b0, 1'b1,  1,  1, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd1, 1'b0, 1'b1, -1, -1, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd1, 1'b0, 1'b1, -2, -1, 8'h0B, 8'hFF, 8'h1A, 8'h02, 8'h1F, 8'h04);
    // Truncation in mode 0
    step_r(2'd0, 1'b1, 1'b1,  0,  1, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd0, 1'b0, 1'b1,  1,  1, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    step_r(2'd0, 1'b0, 1'b1, -2, -1, 8'h0B, 8'hFF, 8'h1A, 8'h01, 8'h1F, 8'h03);
    // Greyscale is never dithered; blank mode zeroes everything
    step_r(2'd2, 1'b1, 1'b1,  0,  1, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F);
    step_r(2'd2, 1'b0, 1'b1,  0,  1, 8'h0B, 8'h0B, 8'h0B, 8'h01, 8'h01, 8'h01);
    step_r(2'd3, 1'b1, 1'b1,  0,  0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 10 && (qe.size() > 0 || qr.size() > 0); i++) @(negedge clk_pix);
    chk("drain", 32'(qe.size() + qr.size()), 32'd0);

    // Asynchronous reset in mid-line on a greyscale frame
    @(posedge clk_pix); #1;
    e_mode = 2'd2; e_fr = 1'b1; e_de = 1'b1; e_x = 16'd7; e_y = 16'd7;
    e_r = 5'h1F; e_g = 5'h1F; e_b = 5'h1F;
    @(posedge clk_pix); #1;
    e_fr = 1'b0; e_mode = 2'd0;
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk("pre_rst_r",    {24'd0, e_or}, 32'hFF);
    chk("pre_rst_x",    {16'd0, e_ox}, 32'd7);
    chk("pre_rst_mcur", {30'd0, e_mcur}, 32'd2);
    #2 rst_pix = 1'b1;
    #1;
    chk("arst_r",    {24'd0, e_or}, 32'd0);
    chk("arst_g",    {24'd0, e_og}, 32'd0);
    chk("arst_x",    {16'd0, e_ox}, 32'd0);
    chk("arst_y",    {16'd0, e_oy}, 32'd0);
    chk("arst_de",   {31'd0, e_ode}, 32'd0);
    chk("arst_mcur", {30'd0, e_mcur}, 32'd0);
    rst_pix = 1'b0;
    @(posedge clk_pix); #1;
    chk("post_rst1_r",  {24'd0, e_or}, 32'd0);
    chk("post_rst1_de", {31'd0, e_ode}, 32'd0);
    @(posedge clk_pix); #1;
    chk("post_rst2_r",  {24'd0, e_or}, 32'hFF);
    chk("post_rst2_x",  {16'd0, e_ox}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_colr_adapt.md
# disp_colr_adapt

Parametrised display output adapter between a design's pixel stream and a board or simulator video sink. It converts any input colour depth to any output depth. Expansion uses bit replication. Reduction uses truncation or 2^n×2^n ordered (Bayer) dithering. It also offers greyscale and blank modes, which are latched once per frame so a mode change never tears mid-frame. Position and sync signals are delayed through a fixed 2-cycle pipeline, so they stay aligned with the colour outputs.

## Interface
- BPC_IN, 5, input bits per colour channel (1–12)
- BPC_OUT, 8, output bits per colour channel (1–12)
- CORDW, 16, signed coordinate width
- DITHER_W, 1, log2 of Bayer matrix side (1 = 2×2, 2 = 4×4)

- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  asynchronous, active-high reset
- mode_req  in  2  requested mode: 0 convert, 1 dither, 2 greyscale, 3 blank
- in_x, in_y  in  CORDW  signed pixel position
- in_de  in  1  data enable
- in_frame  in  1  high one cycle at frame start
- in_r, in_g, in_b  in  BPC_IN  colour channels
- out_x, out_y  out  CORDW  in_x/in_y delayed 2 cycles
- out_de, out_frame  out  1  delayed 2 cycles
- out_r, out_g, out_b  out  BPC_OUT  converted colour
- mode_cur  out  2  mode currently in force

## Operation
- **Mode latch:** mode_cur loads mode_req on any cycle with in_frame=1. That pixel and all later pixels use the new mode. mode_req is ignored at all other times.
- **Expansion (BPC_OUT ≥ BPC_IN):** replicate the input MSB-first ceil(BPC_OUT/BPC_IN) times, then take the top BPC_OUT bits.
  - 5→8 gives {c, c[4:2]}.
  - Mode 1 behaves as mode 0 when expanding.
- **Reduction (D = BPC_IN−BPC_OUT > 0):**
  - Mode 0 truncates: c[BPC_IN−1:D].
  - Mode 1 adds t_s = (t << D) >> (2·DITHER_W). Here t is the Bayer threshold at (in_x, in_y) low DITHER_W bits; these are two's-complement low bits, so negative coordinates wrap naturally.
  - The mode 1 sum is BPC_IN+1 bits wide. It saturates to all-ones before truncation.
  - The 2×2 matrix is [[0,2],[3,1]] in row y, column x. The 4×4 matrix is the standard recursive Bayer matrix.
- **Greyscale (mode 2):** Y = (2r + 5g + b) >> 3, using a BPC_IN+3-bit intermediate. Y is applied to all three channels, then converted as in mode 0 (no dither).
- **Blank (mode 3):** all colour outputs are 0.
- **Blanking:** if the delayed de is 0, out_r/g/b are forced to 0 in every mode.

## Timing
- Latency is exactly 2 clk_pix cycles for every output except mode_cur.
  - Stage 1 registers: position, sync, mode, greyscale value and Bayer threshold.
  - Stage 2 registers: final conversion, saturation and blank forcing.
- mode_cur is registered. It updates the cycle after in_frame. The mode applied to the in_frame pixel itself is taken from mode_req directly (stage-1 mux).
- There is no backpressure, and throughput is one pixel per clock.
- Reset (asynchronous, any time): all outputs and pipeline registers go to 0, including out_x/out_y, and mode_cur goes to 0. After release, the first 2 output cycles are zeros.
- Simultaneous in_frame and mode change: the new mode wins for that pixel.

## Structure
- Package disp_pkg holds:
  - mode constants MODE_CONV/MODE_DITH/MODE_GREY/MODE_BLANK;
  - a Bayer threshold function bayer(x, y, DITHER_W);
  - the width-conversion helper constants.
- Sub-module colr_width handles one channel (convert, dither add, saturate, register). It is instantiated 3×.

## Test plan
- **Expansion:** BPC 5→8, mode 0: in_r=5'h1F → out_r=8'hFF; 5'h10 → 8'h84; 5'h00 → 8'h00. Each appears exactly 2 cycles later, with out_x/out_y matching.
- **Dither:** BPC 8→5, DITHER_W=1, mode 1, input 8'h0B.
  - At (0,0) → 1; (1,0) → 1; (0,1) → 2; (1,1) → 1.
  - At (−1,−1) → 1, since it maps to matrix (1,1).
  - Mode 0 gives 1 everywhere.
- **Saturation:** BPC 8→5, mode 1, input 8'hFF at (0,1) → 5'h1F, with no wrap to 0.
- **Greyscale:** BPC 5→8, mode 2, r=31 g=0 b=0 → all channels 8'h39.
- **Mode latch:** mode_req=3 driven mid-frame → mode_cur and outputs are unchanged until the next in_frame. From that pixel on, out_r/g/b=0 and mode_cur=3 one cycle later.
- **Reset and blanking:** async rst_pix pulse mid-line → outputs 0 immediately and mode_cur=0. Separately, in_de=0 with in_r=5'h1F → out_r=0.
